vector_sweep_gen: RTL and testbench



---
 rtl/sweep_pkg.sv | 42 ++++
 rtl/sweep_misr.sv | 36 +++
 rtl/vector_sweep_gen.sv | 221 ++++++++++++++++++++++
 tb/tb_vector_sweep_gen.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared constants, state encoding and helpers for the vector sweep generator
package sweep_pkg;

  localparam logic [1:0] MODE_BIN  = 2'd0;
  localparam logic [1:0] MODE_GRAY = 2'd1;
  localparam logic [1:0] MODE_WALK = 2'd2;
  localparam logic [1:0] MODE_LFSR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sweep_state_t;

  // Fibonacci tap mask (bit i = stage i+1 of the characteristic polynomial),
  // maximal length for each supported width.
  function automatic logic [7:0] lfsr_taps(input int width);
    case (width)
      2:       return 8'h03;  // x^2+x+1
      3:       return 8'h06;  // x^3+x^2+1
      4:       return 8'h0C;  // x^4+x^3+1
      5:       return 8'h14;  // x^5+x^3+1
      6:       return 8'h30;  // x^6+x^5+1
      7:       return 8'h60;  // x^7+x^6+1
      8:       return 8'hB8;  // x^8+x^6+x^5+x^4+1
      default: return 8'h00;
    endcase
  endfunction

  // One MISR step on a value held in the low 'width' bits of a 16-bit word.
  function automatic logic [15:0] misr_step(input logic [15:0] sig,
                                            input logic [15:0] poly,
                                            input logic [15:0] resp,
                                            input int          width);
    logic [15:0] mask;
    logic        msb;
    mask = 16'((32'd1 << width) - 32'd1);
    msb  = |(sig & 16'(32'd1 << (width - 1)));
    return (((sig << 1) ^ (msb ? poly : 16'h0000) ^ resp) & mask);
  endfunction

endpackage

// File: rtl/sweep_misr.sv
// rtl/sweep_misr.sv - multiple-input signature register compacting the DUT response
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear signature to zero (wins over en)
//   en         : fold resp_in into the signature
//   resp_in    : response word from the device under test
//   sig        : current signature
module sweep_misr
  import sweep_pkg::*;
#(
  parameter int                RESP_W    = 3,
  parameter logic [RESP_W-1:0] MISR_POLY = 3'b011
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [RESP_W-1:0] resp_in,
  output logic [RESP_W-1:0] sig
);

  logic [RESP_W-1:0] r_sig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (clr) begin
      r_sig <= '0;
    end else if (en) begin
      r_sig <= RESP_W'(misr_step(16'(r_sig), 16'(MISR_POLY), 16'(resp_in), RESP_W));
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/vector_sweep_gen.sv
// rtl/vector_sweep_gen.sv - exhaustive stimulus sweeper with MISR response compaction
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a sweep (IDLE only); mode/cont latched with it
//   mode       : 0 binary, 1 gray, 2 walking-one, 3 LFSR
//   cont       : wrap continuously instead of stopping after the last vector
//   pause      : freeze the sweep while high
//   abort      : back to IDLE next cycle, no done/wrap
//   resp_in    : response of the device under test
//   vec_out    : stimulus vector, vec_valid marks it live
//   busy       : sweep in progress
//   done       : one-cycle pulse after the last vector (one-shot)
//   wrap       : one-cycle pulse when the sequence restarts (continuous)
//   sig_out    : signature of the last completed sweep
//   vec_cnt    : 0-based index of the current vector
module vector_sweep_gen
  import sweep_pkg::*;
#(
  parameter int                WIDTH     = 4,
  parameter int                RESP_W    = 3,
  parameter int                HOLD      = 2,
  parameter logic [RESP_W-1:0] MISR_POLY = 3'b011
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              cont,
  input  logic              pause,
  input  logic              abort,
  input  logic [RESP_W-1:0] resp_in,
  output logic [WIDTH-1:0]  vec_out,
  output logic              vec_valid,
  output logic              busy,
  output logic              done,
  output logic              wrap,
  output logic [RESP_W-1:0] sig_out,
  output logic [8:0]        vec_cnt
);

  localparam logic [7:0]       TAPS_ALL  = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAPS_ALL[WIDTH-1:0];
  localparam logic [8:0]       LAST_FULL = 9'((1 << WIDTH) - 1);
  localparam logic [8:0]       LAST_LFSR = 9'((1 << WIDTH) - 2);
  localparam logic [8:0]       LAST_WALK = 9'(WIDTH - 1);
  localparam logic [7:0]       HOLD_LAST = 8'(HOLD - 1);

  sweep_state_t      r_state, w_state_nxt;
  logic [1:0]        r_mode;
  logic              r_cont;
  logic [WIDTH-1:0]  r_vec;
  logic [8:0]        r_cnt;
  logic [7:0]        r_hold;
  logic              r_valid, r_busy, r_done, r_wrap;
  logic [RESP_W-1:0] r_sig_out;

  logic              w_load, w_tick, w_step, w_sample, w_wrap_evt, w_finish, w_to_idle;
  logic              w_last_hold, w_last_vec;
  logic [8:0]        w_last_idx, w_cnt_inc;
  logic [WIDTH-1:0]  w_vec_step;
  logic [RESP_W-1:0] w_sig, w_sig_next;

  function automatic logic [WIDTH-1:0] first_vec(input logic [1:0] m);
    return (m == MODE_WALK || m == MODE_LFSR) ? WIDTH'(1) : '0;
  endfunction

  assign w_cnt_inc   = r_cnt + 9'd1;
  assign w_last_hold = (r_hold == HOLD_LAST);
  assign w_last_vec  = (r_cnt == w_last_idx);

  // Value the MISR will hold after the current sample; captured into sig_out
  // on the same edge that folds in the final response.
  assign w_sig_next = RESP_W'(misr_step(16'(w_sig), 16'(MISR_POLY), 16'(resp_in), RESP_W));

  always_comb begin
    w_last_idx = LAST_FULL;
    w_vec_step = '0;
    case (r_mode)
      MODE_BIN: begin
        w_vec_step = w_cnt_inc[WIDTH-1:0];
      end
      MODE_GRAY: begin
        w_vec_step = w_cnt_inc[WIDTH-1:0] ^ (w_cnt_inc[WIDTH-1:0] >> 1);
      end
      MODE_WALK: begin
        w_last_idx = LAST_WALK;
        w_vec_step = r_vec << 1;
      end
      default: begin
        w_last_idx = LAST_LFSR;
        w_vec_step = {r_vec[WIDTH-2:0], ^(r_vec & TAPS)};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Abort is checked before pause and before last-vector completion.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_tick      = 1'b0;
    w_step      = 1'b0;
    w_sample    = 1'b0;
    w_wrap_evt  = 1'b0;
    w_finish    = 1'b0;
    w_to_idle   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_to_idle   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (!pause) begin
          if (!w_last_hold) begin
            w_tick = 1'b1;
          end else begin
            w_sample = 1'b1;
            if (!w_last_vec) begin
              w_step = 1'b1;
            end else if (r_cont) begin
              w_wrap_evt = 1'b1;
            end else begin
              w_finish    = 1'b1;
              w_state_nxt = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        w_to_idle   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_to_idle   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= MODE_BIN;
      r_cont    <= 1'b0;
      r_vec     <= '0;
      r_cnt     <= '0;
      r_hold    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wrap    <= 1'b0;
      r_sig_out <= '0;
    end else begin
      r_done <= w_finish;
      r_wrap <= w_wrap_evt;
      if (w_load) begin
        r_mode  <= mode;
        r_cont  <= cont;
        r_vec   <= first_vec(mode);
        r_cnt   <= '0;
        r_hold  <= '0;
        r_valid <= 1'b1;
        r_busy  <= 1'b1;
      end else if (w_tick) begin
        r_hold <= r_hold + 8'd1;
      end else if (w_step) begin
        r_vec  <= w_vec_step;
        r_cnt  <= w_cnt_inc;
        r_hold <= '0;
      end else if (w_wrap_evt) begin
        r_vec     <= first_vec(r_mode);
        r_cnt     <= '0;
        r_hold    <= '0;
        r_sig_out <= w_sig_next;
      end else if (w_finish || w_to_idle) begin
        r_vec   <= '0;
        r_cnt   <= '0;
        r_hold  <= '0;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
        if (w_finish) begin
          r_sig_out <= w_sig_next;
        end
      end
    end
  end

  // On wrap the final sample is already captured in sig_out, so clearing
  // takes precedence over the sample in the MISR.
  sweep_misr #(
    .RESP_W    (RESP_W),
    .MISR_POLY (MISR_POLY)
  ) u_misr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_load | w_wrap_evt | w_to_idle),
    .en      (w_sample),
    .resp_in (resp_in),
    .sig     (w_sig)
  );

  assign vec_out   = r_vec;
  assign vec_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign wrap      = r_wrap;
  assign sig_out   = r_sig_out;
  assign vec_cnt   = r_cnt;

endmodule

// File: tb/tb_vector_sweep_gen.sv
// tb/tb_vector_sweep_gen.sv - self-checking bench for vector_sweep_gen (HOLD=1 and HOLD=2 instances)
module tb_vector_sweep_gen;

  localparam int W  = 4;
  localparam int RW = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] mode = 2'd0;

  logic [RW-1:0] resp  [2];
  logic [W-1:0]  vec_o [2];
  logic          valid_o [2];
  logic          busy_o  [2];
  logic          done_o  [2];
  logic          wrap_o  [2];
  logic [RW-1:0] sig_o [2];
  logic [8:0]    cnt_o [2];

  int resp_sel = 0;
  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  vector_sweep_gen #(.WIDTH(W), .RESP_W(RW), .HOLD(1), .MISR_POLY(3'b011)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .cont(cont), .pause(pause),
    .abort(abort), .resp_in(resp[0]), .vec_out(vec_o[0]), .vec_valid(valid_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .wrap(wrap_o[0]), .sig_out(sig_o[0]), .vec_cnt(cnt_o[0])
  );

  vector_sweep_gen #(.WIDTH(W), .RESP_W(RW), .HOLD(2), .MISR_POLY(3'b011)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .cont(cont), .pause(pause),
    .abort(abort), .resp_in(resp[1]), .vec_out(vec_o[1]), .vec_valid(valid_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .wrap(wrap_o[1]), .sig_out(sig_o[1]), .vec_cnt(cnt_o[1])
  );

  // Stand-in gate under test: 0 = AND-reduction, 1 = stuck-at-0, 2 = low bits.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      resp[d] = '0;
      case (resp_sel)
        0:       resp[d] = {2'b00, &vec_o[d]};
        1:       resp[d] = '0;
        default: resp[d] = vec_o[d][2:0];
      endcase
    end
  end

  // ---------------- behavioural model ----------------
  int LFSR_TBL [15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};
  int HOLDV [2] = '{1, 2};

  int       m_st   [2] = '{0, 0};   // 0 idle, 1 running, 2 done cycle
  int       m_pos  [2] = '{0, 0};   // non-paused cycles elapsed in the current pass
  int       m_mode [2] = '{0, 0};
  bit       m_cont [2] = '{0, 0};
  bit       m_wrap [2] = '{0, 0};
  logic [2:0] m_misr [2] = '{3'd0, 3'd0};
  logic [2:0] m_sig  [2] = '{3'd0, 3'd0};

  function automatic int seq_n(input int m);
    case (m)
      0, 1:    return 16;
      2:       return W;
      default: return 15;
    endcase
  endfunction

  function automatic int seq_val(input int m, input int i);
    case (m)
      0:       return i;
      1:       return i ^ (i >> 1);
      2:       return 1 << i;
      default: return LFSR_TBL[i];
    endcase
  endfunction

  function automatic logic [2:0] misr_upd(input logic [2:0] s, input logic [2:0] r);
    return {s[1:0], 1'b0} ^ (s[2] ? 3'b011 : 3'b000) ^ r;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_st[d] = 0; m_pos[d] = 0; m_wrap[d] = 0; m_misr[d] = '0; m_sig[d] = '0;
      end else begin
        m_wrap[d] = 0;
        case (m_st[d])
          0: if (start && !abort) begin
               m_st[d] = 1; m_mode[d] = int'(mode); m_cont[d] = cont;
               m_pos[d] = 0; m_misr[d] = '0;
             end
          1: if (abort) begin
               m_st[d] = 0; m_misr[d] = '0;
             end else if (!pause) begin
               if (m_pos[d] % HOLDV[d] == HOLDV[d] - 1) m_misr[d] = misr_upd(m_misr[d], resp[d]);
               if (m_pos[d] == seq_n(m_mode[d]) * HOLDV[d] - 1) begin
                 m_sig[d] = m_misr[d];
                 if (m_cont[d]) begin
                   m_misr[d] = '0; m_pos[d] = 0; m_wrap[d] = 1;
                 end else begin
                   m_st[d] = 2;
                 end
               end else begin
                 m_pos[d]++;
               end
             end
          default: m_st[d] = 0;
        endcase
      end
    end
  end

  task automatic chk(input string nm, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d", nm, d, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        bit run;
        run = (m_st[d] == 1);
        chk("vec_out",   d, int'(vec_o[d]),   run ? seq_val(m_mode[d], m_pos[d] / HOLDV[d]) : 0);
        chk("vec_cnt",   d, int'(cnt_o[d]),   run ? m_pos[d] / HOLDV[d] : 0);
        chk("vec_valid", d, int'(valid_o[d]), int'(run));
        chk("busy",      d, int'(busy_o[d]),  int'(run));
        chk("done",      d, int'(done_o[d]),  int'(m_st[d] == 2));
        chk("wrap",      d, int'(wrap_o[d]),  int'(m_wrap[d]));
        chk("sig_out",   d, int'(sig_o[d]),   int'(m_sig[d]));
      end
    end
  end

  // ---------------- stimulus ----------------
  int c;
  int done_c [2];
  int wrap_c1 [$];
  int v0_q [$];

  task automatic run_sweep(input int md, input bit ct, input int p_at, input int p_len,
                           input int ab_at, input int st_again_at, input int max_c);
    done_c = '{-1, -1};
    wrap_c1.delete();
    v0_q.delete();
    @(negedge clk);
    mode = 2'(md); cont = ct; start = 1'b1; c = 0;
    while (1) begin
      @(negedge clk);
      c++;
      for (int d = 0; d < 2; d++) if (done_o[d] && done_c[d] < 0) done_c[d] = c;
      if (wrap_o[1]) wrap_c1.push_back(c);
      if (valid_o[0]) v0_q.push_back(int'(vec_o[0]));
      start = (c == st_again_at);
      if (c == 2) mode = 2'(md + 1);
      pause = (c >= p_at && c < p_at + p_len);
      abort = (c == ab_at);
      if (c > 1 && !start && !busy_o[0] && !busy_o[1] && !done_o[0] && !done_o[1]) break;
      if (c >= max_c) begin
        checks++; errors++;
        $display("FAIL sweep_timeout: still busy after %0d cycles, required idle", c);
        break;
      end
    end
    start = 1'b0; pause = 1'b0; abort = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_vec"},   d, int'(vec_o[d]),   0);
      chk({tag, "_valid"}, d, int'(valid_o[d]), 0);
      chk({tag, "_busy"},  d, int'(busy_o[d]),  0);
      chk({tag, "_done"},  d, int'(done_o[d]),  0);
      chk({tag, "_wrap"},  d, int'(wrap_o[d]),  0);
      chk({tag, "_sig"},   d, int'(sig_o[d]),   0);
      chk({tag, "_cnt"},   d, int'(cnt_o[d]),   0);
    end
  endtask

  initial begin
    int seen, good;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1'b1;
    chk_zero("reset");

    // binary one-shot, AND-reduction response: only vector 15 answers 1
    resp_sel = 0;
    run_sweep(0, 0, -1, 0, -1, -1, 60);
    chk("bin_done_cycle", 0, done_c[0], 17);
    chk("bin_done_cycle", 1, done_c[1], 33);
    for (int d = 0; d < 2; d++) chk("bin_and_sig", d, int'(sig_o[d]), 1);

    // abort at cycle 6, with an ignored start at cycle 3
    run_sweep(0, 0, -1, 0, 6, 3, 60);
    chk("abort_latency", 0, c, 7);
    for (int d = 0; d < 2; d++) begin
      chk("abort_vec",      d, int'(vec_o[d]),   0);
      chk("abort_valid",    d, int'(valid_o[d]), 0);
      chk("abort_busy",     d, int'(busy_o[d]),  0);
      chk("abort_no_done",  d, done_c[d],        -1);
      chk("abort_sig_kept", d, int'(sig_o[d]),   1);
    end

    // start and abort together in IDLE
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    for (int d = 0; d < 2; d++) chk("start_abort_idle", d, int'(busy_o[d]), 0);

    // stuck-at-0 response gives a different signature
    resp_sel = 1;
    run_sweep(0, 0, -1, 0, -1, -1, 60);
    for (int d = 0; d < 2; d++) chk("stuck_sig", d, int'(sig_o[d]), 0);

    // gray
    resp_sel = 2;
    run_sweep(1, 0, -1, 0, -1, -1, 60);
    chk("gray_done_cycle", 0, done_c[0], 17);
    chk("gray_done_cycle", 1, done_c[1], 33);
    chk("gray_len", 0, v0_q.size(), 16);
    if (v0_q.size() == 16) begin
      chk("gray_vec3", 0, v0_q[3], 2);
      chk("gray_vec8", 0, v0_q[8], 12);
      chk("gray_vec15", 0, v0_q[15], 8);
    end

    // walking one
    run_sweep(2, 0, -1, 0, -1, -1, 40);
    chk("walk_done_cycle", 0, done_c[0], 5);
    chk("walk_done_cycle", 1, done_c[1], 9);
    chk("walk_len", 0, v0_q.size(), 4);
    if (v0_q.size() == 4) for (int i = 0; i < 4; i++) chk("walk_vec", 0, v0_q[i], 1 << i);

    // LFSR: 15 distinct nonzero vectors starting at 1
    run_sweep(3, 0, -1, 0, -1, -1, 60);
    chk("lfsr_done_cycle", 0, done_c[0], 16);
    chk("lfsr_len", 0, v0_q.size(), 15);
    if (v0_q.size() == 15) begin
      chk("lfsr_first", 0, v0_q[0], 1);
      chk("lfsr_vec3", 0, v0_q[3], 9);
    end
    seen = 0; good = 0;
    foreach (v0_q[i]) if (v0_q[i] != 0 && !seen[v0_q[i]]) begin seen[v0_q[i]] = 1; good++; end
    chk("lfsr_distinct_nonzero", 0, good, 15);

    // continuous walking one, 5-cycle pause mid-vector, abort to stop
    run_sweep(2, 1, 11, 5, 30, -1, 45);
    chk("cont_abort_latency", 0, c, 31);
    for (int d = 0; d < 2; d++) chk("cont_no_done", d, done_c[d], -1);
    chk("cont_wrap_count", 1, wrap_c1.size(), 3);
    if (wrap_c1.size() == 3) begin
      chk("cont_wrap_first", 1, wrap_c1[0], 9);
      chk("cont_wrap_paused", 1, wrap_c1[1], 22);
      chk("cont_wrap_third", 1, wrap_c1[2], 30);
    end

    // asynchronous reset mid-sweep
    @(negedge clk); mode = 2'd1; cont = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk_zero("after_rst");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
